// File: rtl/opcode_type_pkg.sv
// Shared types for I-type arithmetic decode and execution.
// The shift implementation is selected by IMM_ARITH_BARREL_SHIFT_EN.
package opcode_type;

    localparam int IMM_WIDTH = 12;

    typedef enum logic [3:0] {
        iak_invalid = 4'd0,
        iak_addi    = 4'd1,
        iak_slti    = 4'd2,
        iak_sltiu   = 4'd3,
        iak_xori    = 4'd4,
        iak_ori     = 4'd5,
        iak_andi    = 4'd6,
        iak_slli    = 4'd7,
        iak_srli    = 4'd8,
        iak_srai    = 4'd9
    } imm_arith_kind_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } imm_arith_state_t;

    function automatic logic is_shift(input imm_arith_kind_t k);
        return (k == iak_slli) || (k == iak_srli) || (k == iak_srai);
    endfunction

endpackage

// File: rtl/imm_arith_exec_alu.sv
// Combinational single-cycle I-type ALU; also performs the shifts when
// IMM_ARITH_BARREL_SHIFT_EN is defined.
module imm_arith_alu
    import opcode_type::*;
#(
    parameter int XLEN = 32
) (
    input  imm_arith_kind_t       kind,
    input  logic [XLEN-1:0]       rs1,
    input  logic [IMM_WIDTH-1:0]  imm,
    output logic [XLEN-1:0]       result
);

    logic [XLEN-1:0] immx_s;

    assign immx_s = {{(XLEN-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};

`ifdef IMM_ARITH_BARREL_SHIFT_EN
    localparam int SHW = $clog2(XLEN);
    logic [SHW-1:0] shamt_s;
    assign shamt_s = imm[SHW-1:0];
`endif

    // Result selection by decoded kind; unknown or invalid kinds yield zero.
    always_comb begin
        result = {XLEN{1'b0}};
        case (kind)
            iak_addi:  result = rs1 + immx_s;
            iak_slti:  result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(immx_s))};
            iak_sltiu: result = {{(XLEN-1){1'b0}}, (rs1 < immx_s)};
            iak_xori:  result = rs1 ^ immx_s;
            iak_ori:   result = rs1 | immx_s;
            iak_andi:  result = rs1 & immx_s;
`ifdef IMM_ARITH_BARREL_SHIFT_EN
            iak_slli:  result = rs1 << shamt_s;
            iak_srli:  result = rs1 >> shamt_s;
            iak_srai:  result = $unsigned($signed(rs1) >>> shamt_s);
`endif
            default:   result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/imm_arith_exec.sv
// I-type arithmetic sequencer: valid/ready in, single-cycle ALU ops, and an
// iterative 1-bit/cycle shifter (combinational when IMM_ARITH_BARREL_SHIFT_EN).
module imm_arith_exec
    import opcode_type::*;
#(
    parameter int XLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  imm_arith_kind_t       kind,
    input  logic [XLEN-1:0]       rs1,
    input  logic [IMM_WIDTH-1:0]  imm,
    input  logic [4:0]            in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [4:0]            out_rd,
    output logic                  out_illegal,
    output logic                  busy
);

    localparam int SHW = $clog2(XLEN);

    imm_arith_state_t state_q, state_d;
    logic             accept_s;
    logic             start_shift_s;
    logic [SHW-1:0]   shamt_s;
    logic [XLEN-1:0]  alu_result_s;
    logic [XLEN-1:0]  result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic             illegal_q, illegal_d;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_s = in_valid && in_ready;
    assign shamt_s  = imm[SHW-1:0];

    imm_arith_alu #(.XLEN(XLEN)) u_alu (
        .kind   (kind),
        .rs1    (rs1),
        .imm    (imm),
        .result (alu_result_s)
    );

`ifdef IMM_ARITH_BARREL_SHIFT_EN
    assign start_shift_s = 1'b0;
`else
    logic [XLEN-1:0] acc_q, acc_d, acc_shift_s;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            left_q, left_d, arith_q, arith_d;

    assign start_shift_s = is_shift(kind) && (shamt_s != {SHW{1'b0}});
    assign acc_shift_s   = left_q ? {acc_q[XLEN-2:0], 1'b0}
                                  : {arith_q & acc_q[XLEN-1], acc_q[XLEN-1:1]};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = start_shift_s ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
`ifndef IMM_ARITH_BARREL_SHIFT_EN
            SHIFT: begin
                if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
`endif
            DONE: begin
                if (!out_ready) begin
                    state_d = DONE;
                end else if (accept_s) begin
                    state_d = start_shift_s ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load on accept, step the shifter while in SHIFT.
    always_comb begin
        result_d  = result_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
`ifndef IMM_ARITH_BARREL_SHIFT_EN
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
`endif
        if (accept_s) begin
            rd_d      = in_rd;
            illegal_d = (kind == iak_invalid);
`ifdef IMM_ARITH_BARREL_SHIFT_EN
            result_d  = alu_result_s;
`else
            result_d  = is_shift(kind) ? rs1 : alu_result_s;
            acc_d     = rs1;
            cnt_d     = shamt_s;
            left_d    = (kind == iak_slli);
            arith_d   = (kind == iak_srai);
        end else if (state_q == SHIFT) begin
            // result tracks acc so it holds the final value when cnt reaches 1
            acc_d    = acc_shift_s;
            cnt_d    = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
            result_d = acc_shift_s;
`endif
        end else begin
            result_d = result_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= {XLEN{1'b0}};
            rd_q      <= 5'd0;
            illegal_q <= 1'b0;
`ifndef IMM_ARITH_BARREL_SHIFT_EN
            acc_q     <= {XLEN{1'b0}};
            cnt_q     <= {SHW{1'b0}};
            left_q    <= 1'b0;
            arith_q   <= 1'b0;
`endif
        end else begin
            result_q  <= result_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
`ifndef IMM_ARITH_BARREL_SHIFT_EN
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            arith_q   <= arith_d;
`endif
        end
    end

    // Output decode from registered state.
    always_comb begin
        out_valid   = (state_q == DONE);
`ifdef IMM_ARITH_BARREL_SHIFT_EN
        busy        = 1'b0;
`else
        busy        = (state_q == SHIFT);
`endif
        out_result  = result_q;
        out_rd      = rd_q;
        out_illegal = illegal_q;
    end

endmodule

// File: tb/tb_imm_arith_exec.sv
// Directed self-checking bench for imm_arith_exec (iterative shifter build).
module tb_imm_arith_exec;
    import opcode_type::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    imm_arith_kind_t kind;
    logic [31:0]     rs1;
    logic [11:0]     imm;
    logic [4:0]      in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_result;
    logic [4:0]      out_rd;
    logic            out_illegal;
    logic            busy;

    int errors = 0;
    int checks = 0;

    imm_arith_exec #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .kind        (kind),
        .rs1         (rs1),
        .imm         (imm),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input imm_arith_kind_t k, input logic [31:0] a,
                         input logic [11:0] i, input logic [4:0] rd);
        in_valid = 1'b1;
        kind     = k;
        rs1      = a;
        imm      = i;
        in_rd    = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; kind = iak_invalid; rs1 = 32'd0;
        imm = 12'd0; in_rd = 5'd0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, in_ready, out_illegal, out_rd, out_result} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset: valid=%b busy=%b rdy=%b ill=%b rd=%0d res=%h", out_valid,
                     busy, in_ready, out_illegal, out_rd, out_result);
        end
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        offer(iak_addi, 32'd5, 12'hFFF, 5'd7);
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_rd, out_result} !== {1'b1, 5'd7, 32'd4}) begin
            errors++;
            $display("FAIL addi: valid=%b rd=%0d res=%h want 1 7 4", out_valid, out_rd, out_result);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_one_cycle: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_shifts();
        imm_arith_kind_t ks[3]  = '{iak_srai, iak_srli, iak_slli};
        logic [31:0]     as[3]  = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001};
        logic [11:0]     is[3]  = '{12'h404, 12'h004, 12'h01F};
        logic [31:0]     es[3]  = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000};
        int              ns[3]  = '{4, 4, 31};
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            offer(ks[v], as[v], is[v], 5'd3);
            step();
            in_valid = 1'b0;
            for (int c = 0; c < ns[v]; c++) begin
                checks++;
                if ({busy, in_ready, out_valid} !== 3'b100) begin
                    errors++;
                    $display("FAIL shift%0d_busy c%0d: busy=%b rdy=%b valid=%b want 1 0 0",
                             v, c, busy, in_ready, out_valid);
                end
                step();
            end
            checks++;
            if ({out_valid, busy, out_result} !== {1'b1, 1'b0, es[v]}) begin
                errors++;
                $display("FAIL shift%0d_result: valid=%b busy=%b res=%h want %h",
                         v, out_valid, busy, out_result, es[v]);
            end
            step();
        end
    endtask

    task automatic test_compare();
        imm_arith_kind_t ks[3] = '{iak_sltiu, iak_slti, iak_slti};
        logic [31:0]     as[3] = '{32'd1, 32'd1, 32'hFFFF_FFFF};
        logic [11:0]     is[3] = '{12'hFFF, 12'hFFF, 12'h000};
        logic [31:0]     es[3] = '{32'd1, 32'd0, 32'd1};
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            offer(ks[v], as[v], is[v], 5'd4);
            step();
            in_valid = 1'b0;
            checks++;
            if ({out_valid, out_result} !== {1'b1, es[v]}) begin
                errors++;
                $display("FAIL compare%0d: valid=%b res=%h want %h", v, out_valid, out_result, es[v]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(iak_xori, 32'hF0F0_F0F0, 12'h0FF, 5'd8);
        step();
        offer(iak_andi, 32'hFFFF_FFFF, 12'h800, 5'd9);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({out_valid, in_ready, out_rd, out_result} !== {1'b1, 1'b0, 5'd8, 32'hF0F0_F00F}) begin
                errors++;
                $display("FAIL hold c%0d: valid=%b rdy=%b rd=%0d res=%h want 1 0 8 f0f0f00f",
                         c, out_valid, in_ready, out_rd, out_result);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: rdy=%b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_rd, out_result} !== {1'b1, 5'd9, 32'hFFFF_F800}) begin
            errors++;
            $display("FAIL second_op: valid=%b rd=%0d res=%h want 1 9 fffff800",
                     out_valid, out_rd, out_result);
        end
        step();
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        out_ready = 1'b1;
        offer(iak_slli, 32'd1, 12'h00A, 5'd5);
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid_shift: valid=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
        end
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_discard: active cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_invalid_and_zero_shift();
        out_ready = 1'b1;
        offer(iak_invalid, 32'h1234_5678, 12'h005, 5'd10);
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_illegal, out_result} !== {1'b1, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL invalid: valid=%b ill=%b res=%h want 1 1 0", out_valid, out_illegal, out_result);
        end
        step();
        offer(iak_ori, 32'd0, 12'h0F0, 5'd11);
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_illegal, out_result} !== {1'b1, 1'b0, 32'h0000_00F0}) begin
            errors++;
            $display("FAIL ori: valid=%b ill=%b res=%h want 1 0 000000f0", out_valid, out_illegal, out_result);
        end
        step();
        offer(iak_srli, 32'hDEAD_BEEF, 12'h000, 5'd12);
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, busy, out_rd, out_result} !== {1'b1, 1'b0, 5'd12, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL srli_zero: valid=%b busy=%b rd=%0d res=%h want 1 0 12 deadbeef",
                     out_valid, busy, out_rd, out_result);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        offer(iak_addi, 32'd100, 12'h001, 5'd1);
        step();
        offer(iak_addi, 32'd200, 12'h002, 5'd2);
        checks++;
        if ({out_valid, in_ready, out_result} !== {1'b1, 1'b1, 32'd101}) begin
            errors++;
            $display("FAIL b2b_first: valid=%b rdy=%b res=%0d want 1 1 101", out_valid, in_ready, out_result);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_rd, out_result} !== {1'b1, 5'd2, 32'd202}) begin
            errors++;
            $display("FAIL b2b_second: valid=%b rd=%0d res=%0d want 1 2 202", out_valid, out_rd, out_result);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_shifts();
        test_compare();
        test_backpressure();
        test_reset_mid_shift();
        test_invalid_and_zero_shift();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_arith_exec.md
# imm_arith_exec

Sequencing controller for I-type arithmetic execution in the core. Sits after `imm_arith_type` decode. Accepts one decoded operation (`imm_arith_kind_t`, rs1 value, 12-bit immediate, destination tag) over a valid/ready handshake. Single-cycle ops complete in one cycle; SLLI/SRLI/SRAI run on an iterative one-bit-per-cycle shifter under an FSM. The result is held on a valid/ready output toward writeback.

## Interface
- `XLEN`, default 32: datapath width. Shift amount width is `$clog2(XLEN)`, taken from `imm[$clog2(XLEN)-1:0]`.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: operation offered.
- `in_ready` output 1: block can accept this cycle.
- `kind` input `imm_arith_kind_t`: decoded operation.
- `rs1` input XLEN: source operand.
- `imm` input 12: raw I-immediate.
- `in_rd` input 5: destination register tag, passed through unchanged.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output XLEN: result.
- `out_rd` output 5: tag of the result.
- `out_illegal` output 1: the operation was `iak_invalid`.
- `busy` output 1: high in the SHIFT state.

## Operation
- States: IDLE, SHIFT, DONE.
- Accept occurs when `in_valid && in_ready`.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready).
- `in_ready` is combinational from state and `out_ready`. It never depends on `in_valid`.
- Sign extension: immx = {{(XLEN-12){imm[11]}}, imm}.
- On accept of a non-shift op:
  - result is computed from rs1 and immx, then go to DONE.
  - ADDI wraps modulo 2^XLEN.
  - SLTI is a signed compare; SLTIU is an unsigned compare against immx. Both return 0 or 1, zero-extended.
  - XORI, ORI and ANDI are bitwise.
- On accept of `iak_invalid`: result 0, `out_illegal`=1, go to DONE.
- On accept of a shift:
  - shamt==0: result = rs1, go to DONE.
  - shamt>0: load acc=rs1 and cnt=shamt, latch the direction/arith flag, go to SHIFT.
- In SHIFT, each cycle:
  - acc shifts one bit: left with 0 fill, logical right with 0 fill, or arithmetic right with acc[XLEN-1] fill.
  - cnt decrements by 1.
  - When cnt==1 at the edge, the final shift is applied and the state moves to DONE.
- In DONE:
  - `out_valid`=1. `out_result`, `out_rd` and `out_illegal` are stable until handshake.
  - On `out_ready`: if a new op is accepted the same cycle, process it as from IDLE; otherwise go to IDLE.
- `in_*` inputs are ignored while `in_ready`=0.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_result` 0, `out_rd` 0, `out_illegal` 0, `busy` 0, `in_ready` 1, acc 0, cnt 0.
- Accept at edge N:
  - Non-shift, invalid, or shamt 0: `out_valid`=1 from cycle N+1.
  - Shift with shamt s>0: `busy`=1 for cycles N+1..N+s, `out_valid`=1 from cycle N+1+s.
- Throughput is one op per cycle for single-cycle ops when `out_ready` is held high (back-to-back through DONE).
- `rst` in any state, including mid-shift, wins over every other event. The next cycle is at reset values and the in-flight op is discarded with no output.
- `out_valid` is never dropped without handshake.

## Configuration
- `IMM_ARITH_BARREL_SHIFT_EN` defined:
  - shifts are computed combinationally in one cycle, with the same latency as ADDI.
  - SHIFT state, acc and cnt are not compiled; `busy` is tied 0.
- Undefined: iterative shifter as described above.

## Structure
- Package `opcode_type` holds:
  - `imm_arith_kind_t` (existing).
  - new `imm_arith_state_t` (IDLE, SHIFT, DONE).
  - constant `IMM_WIDTH`=12.
- Sub-module `imm_arith_alu`: combinational single-cycle ops (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, invalid → 0).
  - Under `IMM_ARITH_BARREL_SHIFT_EN` it also handles the shifts.
  - The FSM and iterative shifter stay in `imm_arith_exec`.

## Test plan
- ADDI rs1=5, imm=12'hFFF, `out_ready`=1 → `out_result`=4, `out_valid` exactly one cycle after accept, `out_rd` echoes `in_rd`.
- SRAI rs1=32'h8000_0000, shamt=4 → 32'hF800_0000 at accept+5, `busy` high 4 cycles, `in_ready` 0 throughout. SRLI same operands → 32'h0800_0000. SLLI rs1=1, shamt=31 → 32'h8000_0000.
- SLTIU rs1=1, imm=12'hFFF → 1. SLTI rs1=1, imm=12'hFFF → 0. SLTI rs1=32'hFFFF_FFFF, imm=0 → 1.
- Hold `out_ready`=0 for 3 cycles after an XORI result → `out_valid` and `out_result` stable, `in_ready`=0, offered second op not accepted. Raise `out_ready` with the second op valid → second op accepted that cycle, its result the next cycle.
- Assert `rst` during SLLI with shamt=10 at the 3rd busy cycle → next cycle IDLE, `out_valid`=0, `busy`=0, `in_ready`=1, and no result ever appears.
- `kind`=`iak_invalid` → `out_illegal`=1, `out_result`=0, latency 1. Then ORI rs1=0, imm=12'h0F0 → 32'h0000_00F0 with `out_illegal`=0. SRLI shamt=0 → rs1 unchanged, latency 1.
